// File: rtl/regfile_wb_sched.sv
// Register-file write-port scheduler: pipe writeback has priority, multi-cycle results queue in a FIFO.
// Optional starvation guard (wb_hold) is built when REGFILE_WB_STARVE_EN is defined.
module regfile_wb_sched #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wr_en,
  input  logic [4:0]  pipe_wr_addr,
  input  logic [31:0] pipe_wr_data,
  input  logic        mc_issue,
  input  logic [4:0]  mc_issue_addr,
  input  logic        mc_valid,
  input  logic [4:0]  mc_addr,
  input  logic [31:0] mc_data,
  output logic        mc_ready,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  output logic        id_stall,
  output logic        wb_hold,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = PW + 1;

  logic [4:0]       addr_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [31:1]      pending_reg;
  logic [31:0]      pending;

  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic [4:0]  head_addr;
  logic [31:0] head_data;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign mc_ready  = !full;
  assign push      = mc_valid && !full;
  assign pop       = !pipe_wr_en && !empty;
  assign head_addr = addr_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];

  // Write-port mux: the pipe always wins, the FIFO head only fills idle slots.
  always_comb begin
    sel_addr = 5'd0;
    sel_data = 32'd0;
    if (pipe_wr_en) begin
      sel_addr = pipe_wr_addr;
      sel_data = pipe_wr_data;
    end else if (pop) begin
      sel_addr = head_addr;
      sel_data = head_data;
    end
  end

  assign rf_wr_en   = rst && (pipe_wr_en || pop) && (sel_addr != 5'd0);
  assign rf_wr_addr = rst ? sel_addr : 5'd0;
  assign rf_wr_data = rst ? sel_data : 32'd0;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= mc_addr;
      data_mem[wr_ptr_reg] <= mc_data;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
    end
  end

  // One flop per architectural register; a new issue overrides a same-edge retirement.
  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_pend
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          pending_reg[gi] <= 1'b0;
        else if (mc_issue && (mc_issue_addr == 5'(gi)))
          pending_reg[gi] <= 1'b1;
        else if (pop && (head_addr == 5'(gi)))
          pending_reg[gi] <= 1'b0;
      end
    end
  endgenerate

  assign pending  = {pending_reg, 1'b0};
  assign id_stall = pending[id_rs_addr] | pending[id_rt_addr];

`ifdef REGFILE_WB_STARVE_EN
  logic [3:0] starve_cnt_reg;
  logic       blocked;

  assign blocked = pipe_wr_en && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      starve_cnt_reg <= 4'd0;
    else if (!blocked)
      starve_cnt_reg <= 4'd0;
    else if (starve_cnt_reg != 4'(STARVE_MAX))
      starve_cnt_reg <= starve_cnt_reg + 4'd1;
  end

  // Raised in the blocked cycle that brings the count to STARVE_MAX so W idles the very next cycle.
  assign wb_hold = blocked && (starve_cnt_reg >= 4'(STARVE_MAX - 1));
`else
  assign wb_hold = 1'b0;
`endif

endmodule
